parallella_gpio_ctrl: RTL and testbench

//  Parametrised PS-side GPIO controller for the Parallella GPIO header, one clock domain.

---
 rtl/parallella_gpio_ctrl.sv | 139 +++++++++++++
 tb/tb_parallella_gpio_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/parallella_gpio_ctrl.sv
// GPIO controller for the Parallella header: per-pin direction/output registers,
// synchronised and debounced inputs, and edge-triggered maskable interrupts.
module parallella_gpio_ctrl #(
  parameter int unsigned NUM_GPIO    = 48,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                reg_wr,
  input  logic [2:0]          reg_addr,
  input  logic [NUM_GPIO-1:0] reg_wdata,
  output logic [NUM_GPIO-1:0] reg_rdata,
  input  logic [NUM_GPIO-1:0] pad_i,
  output logic [NUM_GPIO-1:0] pad_o,
  output logic [NUM_GPIO-1:0] pad_t,
  output logic                irq
);

  localparam int unsigned N  = NUM_GPIO;
  localparam int unsigned DW = DEBOUNCE_W;

  localparam logic [2:0] A_OUT   = 3'd0;
  localparam logic [2:0] A_DIR   = 3'd1;
  localparam logic [2:0] A_IN    = 3'd2;
  localparam logic [2:0] A_IEN   = 3'd3;
  localparam logic [2:0] A_IPOL  = 3'd4;
  localparam logic [2:0] A_ISTAT = 3'd5;
  localparam logic [2:0] A_DBLIM = 3'd6;

  logic [N-1:0]  out_q, out_d;
  logic [N-1:0]  tri_q, tri_d;
  logic [N-1:0]  ien_q, ien_d;
  logic [N-1:0]  ipol_q, ipol_d;
  logic [N-1:0]  istat_q, istat_d;
  logic [DW-1:0] dblim_q, dblim_d;
  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  stable_q, stable_d;
  logic [N-1:0]  stable_dly_q;
  logic [DW-1:0] cnt_q [N];
  logic [DW-1:0] cnt_d [N];
  logic [N-1:0]  rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic [N-1:0]  sync_c;
  logic [N-1:0]  rise_c, fall_c, edge_c, w1c_c;

  // Register writes, debounce, edge capture and read mux.
  always_comb begin
    out_d   = out_q;
    tri_d   = tri_q;
    ien_d   = ien_q;
    ipol_d  = ipol_q;
    dblim_d = dblim_q;
    w1c_c   = '0;

    if (reg_wr) begin
      case (reg_addr)
        A_OUT:   out_d   = reg_wdata;
        A_DIR:   tri_d   = ~reg_wdata;
        A_IEN:   ien_d   = reg_wdata;
        A_IPOL:  ipol_d  = reg_wdata;
        A_ISTAT: w1c_c   = reg_wdata;
        A_DBLIM: dblim_d = reg_wdata[DW-1:0];
        default: ;
      endcase
    end

    // A limit lowered below a running count releases on the next mismatch.
    sync_c   = sync_q[SYNC_STAGES-1];
    stable_d = stable_q;
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_c[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= dblim_q) begin
        stable_d[i] = sync_c[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end

    // New edges override a same-cycle clear.
    rise_c  = stable_q & ~stable_dly_q;
    fall_c  = ~stable_q & stable_dly_q;
    edge_c  = (ipol_q & rise_c) | (~ipol_q & fall_c);
    istat_d = (istat_q & ~w1c_c) | edge_c;
    irq_d   = |(istat_q & ien_q);

    case (reg_addr)
      A_OUT:   rdata_d = out_q;
      A_DIR:   rdata_d = ~tri_q;
      A_IN:    rdata_d = stable_q;
      A_IEN:   rdata_d = ien_q;
      A_IPOL:  rdata_d = ipol_q;
      A_ISTAT: rdata_d = istat_q;
      A_DBLIM: rdata_d = N'(dblim_q);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      tri_q        <= '1;
      ien_q        <= '0;
      ipol_q       <= '0;
      istat_q      <= '0;
      dblim_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
    end else begin
      out_q        <= out_d;
      tri_q        <= tri_d;
      ien_q        <= ien_d;
      ipol_q       <= ipol_d;
      istat_q      <= istat_d;
      dblim_q      <= dblim_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
      sync_q[0]    <= pad_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < int'(N); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pad_o     = out_q;
  assign pad_t     = tri_q;
  assign reg_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_parallella_gpio_ctrl.sv
// Directed bench for parallella_gpio_ctrl: registers, debounce timing, interrupts,
// set/clear collision, masking, narrow-parameter DBLIM and asynchronous reset.
module tb_parallella_gpio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_wr;
  logic [2:0]  reg_addr;
  logic [47:0] reg_wdata;
  logic [47:0] reg_rdata;
  logic [47:0] pad_i;
  logic [47:0] pad_o;
  logic [47:0] pad_t;
  logic        irq;

  logic        s_wr;
  logic [2:0]  s_addr;
  logic [19:0] s_wdata;
  logic [19:0] s_rdata;
  logic [19:0] s_pad_i;
  logic [19:0] s_pad_o;
  logic [19:0] s_pad_t;
  logic        s_irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parallella_gpio_ctrl #(.NUM_GPIO(48), .SYNC_STAGES(2), .DEBOUNCE_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .pad_i(pad_i),
    .pad_o(pad_o), .pad_t(pad_t), .irq(irq)
  );

  parallella_gpio_ctrl #(.NUM_GPIO(20), .SYNC_STAGES(2), .DEBOUNCE_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .reg_wr(s_wr), .reg_addr(s_addr),
    .reg_wdata(s_wdata), .reg_rdata(s_rdata), .pad_i(s_pad_i),
    .pad_o(s_pad_o), .pad_t(s_pad_t), .irq(s_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [47:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [47:0] d);
    reg_addr = a;
    @(negedge clk);
    d = reg_rdata;
  endtask

  logic [47:0] v;

  initial begin
    reset_n = 1'b0; reg_wr = 1'b0; reg_addr = 3'd0; reg_wdata = '0; pad_i = '0;
    s_wr = 1'b0; s_addr = 3'd0; s_wdata = '0; s_pad_i = '0;
    tick(3);
    check("reset_pad_t", 64'(pad_t), 64'hFFFF_FFFF_FFFF);
    check("reset_pad_o", 64'(pad_o), 64'h0);
    check("reset_irq", 64'(irq), 64'h0);
    check("reset_rdata", 64'(reg_rdata), 64'h0);
    reset_n = 1'b1;
    tick(1);

    // Direction and output registers
    wr(3'd1, 48'h3);
    check("dir_pad_t", 64'(pad_t), 64'hFFFF_FFFF_FFFC);
    wr(3'd0, 48'h1);
    check("out_pad_o", 64'(pad_o), 64'h1);
    rd(3'd0, v); check("rd_out", 64'(v), 64'h1);
    rd(3'd1, v); check("rd_dir", 64'(v), 64'h3);
    rd(3'd7, v); check("rd_reserved", 64'(v), 64'h0);

    // Debounce with L=3: a 3-cycle pulse is rejected
    wr(3'd6, 48'h3);
    rd(3'd6, v); check("rd_dblim", 64'(v), 64'h3);
    reg_addr = 3'd2;
    pad_i[5] = 1'b1; tick(3);
    pad_i[5] = 1'b0; tick(10);
    check("glitch_rejected", 64'(reg_rdata), 64'h0);

    // A held high reaches IN after 2+4 cycles; reg_rdata adds one more
    pad_i[5] = 1'b1; tick(6);
    check("in_before_latency", 64'(reg_rdata), 64'h0);
    tick(1);
    check("in_after_latency", 64'(reg_rdata), 64'h20);

    // Rising-edge select on pin 5, then a falling edge sets nothing
    wr(3'd4, 48'h20);
    wr(3'd6, 48'h0);
    pad_i[5] = 1'b0; tick(8);
    rd(3'd5, v); check("fall_no_status", 64'(v), 64'h0);

    // Enabled rising edge with L=0
    wr(3'd3, 48'h20);
    reg_addr = 3'd5;
    pad_i[5] = 1'b1; tick(4);
    check("irq_before_stat", 64'(irq), 64'h0);
    tick(1);
    check("istat_set", 64'(reg_rdata), 64'h20);
    check("irq_set", 64'(irq), 64'h1);
    wr(3'd5, 48'h20);
    check("irq_after_w1c_1", 64'(irq), 64'h1);
    tick(1);
    check("irq_after_w1c_2", 64'(irq), 64'h0);
    rd(3'd5, v); check("istat_cleared", 64'(v), 64'h0);
    pad_i[5] = 1'b0; tick(8);
    rd(3'd5, v); check("fall_no_status_2", 64'(v), 64'h0);
    check("irq_after_fall", 64'(irq), 64'h0);

    // Clear and a new rising edge land on the same clock edge
    pad_i[5] = 1'b1; tick(3);
    reg_wr = 1'b1; reg_addr = 3'd5; reg_wdata = 48'h20;
    tick(1);
    reg_wr = 1'b0;
    rd(3'd5, v); check("set_beats_clear", 64'(v), 64'h20);
    wr(3'd5, 48'h20);
    rd(3'd5, v); check("istat_cleared_2", 64'(v), 64'h0);
    pad_i[5] = 1'b0; tick(8);

    // Masked edge still records status
    wr(3'd3, 48'h0);
    pad_i[5] = 1'b1; tick(8);
    rd(3'd5, v); check("masked_status", 64'(v), 64'h20);
    check("masked_irq", 64'(irq), 64'h0);
    wr(3'd3, 48'h20);
    tick(2);
    check("unmasked_irq", 64'(irq), 64'h1);

    // Narrow instance: DBLIM keeps only DEBOUNCE_W bits
    check("small_pad_t", 64'(s_pad_t), 64'hF_FFFF);
    s_wr = 1'b1; s_addr = 3'd6; s_wdata = 20'hFF;
    tick(1);
    s_wr = 1'b0;
    tick(1);
    check("small_dblim", 64'(s_rdata), 64'hF);

    // Asynchronous reset with an interrupt pending
    #2 reset_n = 1'b0;
    #1;
    check("async_pad_t", 64'(pad_t), 64'hFFFF_FFFF_FFFF);
    check("async_pad_o", 64'(pad_o), 64'h0);
    check("async_irq", 64'(irq), 64'h0);
    check("async_rdata", 64'(reg_rdata), 64'h0);
    pad_i = '0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      check($sformatf("post_reset_reg%0d", a), 64'(v), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
